oc_q4: RTL and testbench



---
 rtl/oc_q4_pkg.sv | 11 +
 rtl/oc_q4_if.sv | 15 +
 rtl/oc_q4_stage.sv | 11 +
 rtl/oc_q4.sv | 46 ++++
 tb/tb_oc_q4.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/oc_q4_pkg.sv
// Shared constants for the open-collector Q4 block: stage counts per node
// and the released-bus reset values.
package oc_pkg;

    localparam int NODE0_STAGES = 2;
    localparam int NODE1_STAGES = 3;

    localparam logic                    Y_RST  = 1'b1;
    localparam logic [NODE1_STAGES-1:0] PD_RST = '0;

endpackage

// File: rtl/oc_q4_if.sv
// Bundle of the three data inputs and the resolved/pull-down outputs of oc_q4.
interface oc_q4_if
    import oc_pkg::*;
;
    logic                    a;
    logic                    b;
    logic                    c;
    logic                    y0;
    logic                    y1;
    logic [NODE0_STAGES-1:0] pd0;
    logic [NODE1_STAGES-1:0] pd1;

    modport master (output a, b, c, input y0, y1, pd0, pd1);
    modport slave  (input a, b, c, output y0, y1, pd0, pd1);
endinterface

// File: rtl/oc_q4_stage.sv
// One open-collector pull-down stage: conducts when every input is high.
module oc_stage #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_in,
    output logic         o_pd
);

    assign o_pd = &i_in;

endmodule

// File: rtl/oc_q4.sv
// Registered model of two wired-AND nodes; each node reads high only while
// none of its pull-down stages conducts.
module oc_q4
    import oc_pkg::*;
(
    input logic     clk,
    input logic     rst,
    oc_q4_if.slave  bus
);

    logic [NODE0_STAGES-1:0] w_pd0;
    logic [NODE1_STAGES-1:0] w_pd1;

    logic [NODE0_STAGES-1:0] r_pd0;
    logic [NODE1_STAGES-1:0] r_pd1;
    logic                    r_y0;
    logic                    r_y1;

    oc_stage #(.N(2)) u_n0_ab (.i_in({bus.a, bus.b}), .o_pd(w_pd0[0]));
    oc_stage #(.N(1)) u_n0_c  (.i_in(bus.c),          .o_pd(w_pd0[1]));

    oc_stage #(.N(2)) u_n1_ab (.i_in({bus.a, bus.b}), .o_pd(w_pd1[0]));
    oc_stage #(.N(2)) u_n1_bc (.i_in({bus.b, bus.c}), .o_pd(w_pd1[1]));
    oc_stage #(.N(2)) u_n1_ac (.i_in({bus.a, bus.c}), .o_pd(w_pd1[2]));

    // Node levels are derived from the same sampled enables so yN == ~|pdN always holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pd0 <= PD_RST[NODE0_STAGES-1:0];
            r_pd1 <= PD_RST;
            r_y0  <= Y_RST;
            r_y1  <= Y_RST;
        end else begin
            r_pd0 <= w_pd0;
            r_pd1 <= w_pd1;
            r_y0  <= ~|w_pd0;
            r_y1  <= ~|w_pd1;
        end
    end

    assign bus.pd0 = r_pd0;
    assign bus.pd1 = r_pd1;
    assign bus.y0  = r_y0;
    assign bus.y1  = r_y1;

endmodule

// File: tb/tb_oc_q4.sv
// Self-checking bench for oc_q4: vector table, directed corner sequences,
// and randomized traffic against a truth-level reference model.
module tb_oc_q4;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    bit   consistOn;

    oc_q4_if bus ();

    oc_q4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] abc;
        logic       y0;
        logic       y1;
        logic [1:0] pd0;
        logic [2:0] pd1;
    } vec_t;

    // Drive at the falling edge, then move to just after the rising edge.
    task automatic applyStimulus(input logic r, input logic [2:0] abc);
        @(negedge clk);
        rst   = r;
        bus.a = abc[2];
        bus.b = abc[1];
        bus.c = abc[0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ey0, input logic ey1,
                               input logic [1:0] epd0, input logic [2:0] epd1);
        compared++;
        if (bus.y0 !== ey0 || bus.y1 !== ey1 || bus.pd0 !== epd0 || bus.pd1 !== epd1) begin
            mismatched++;
            $display("[TB] FAIL %s: got y0=%b y1=%b pd0=%b pd1=%b, want y0=%b y1=%b pd0=%b pd1=%b",
                     name, bus.y0, bus.y1, bus.pd0, bus.pd1, ey0, ey1, epd0, epd1);
        end
    endtask

    // Reference: a node is pulled low by any conducting stage; node 1 is the inverted majority.
    task automatic refModel(input logic r, input logic [2:0] abc,
                            output logic ey0, output logic ey1,
                            output logic [1:0] epd0, output logic [2:0] epd1);
        int ones;
        logic a, b, c;
        a = abc[2];
        b = abc[1];
        c = abc[0];
        if (r) begin
            ey0 = 1'b1; ey1 = 1'b1; epd0 = 2'b00; epd1 = 3'b000;
        end else begin
            ones = int'(a) + int'(b) + int'(c);
            epd0 = {c, a & b};
            epd1 = {a & c, b & c, a & b};
            ey0  = !(c || (a && b));
            ey1  = (ones < 2);
        end
    endtask

    always @(negedge clk) begin
        if (consistOn) begin
            compared++;
            if (bus.y0 !== ~|bus.pd0 || bus.y1 !== ~|bus.pd1) begin
                mismatched++;
                $display("[TB] FAIL consistency: got y0=%b pd0=%b y1=%b pd1=%b, want yN == ~|pdN",
                         bus.y0, bus.pd0, bus.y1, bus.pd1);
            end
        end
    end

    initial begin
        vec_t vecs[10];
        logic ey0, ey1;
        logic [1:0] epd0;
        logic [2:0] epd1;
        logic [2:0] rabc;
        logic rr;

        compared   = 0;
        mismatched = 0;
        consistOn  = 1'b0;
        rst   = 1'b1;
        bus.a = 1'b1;
        bus.b = 1'b1;
        bus.c = 1'b1;

        vecs[0] = '{1'b1, 3'b111, 1'b1, 1'b1, 2'b00, 3'b000};
        vecs[1] = '{1'b1, 3'b111, 1'b1, 1'b1, 2'b00, 3'b000};
        vecs[2] = '{1'b0, 3'b000, 1'b1, 1'b1, 2'b00, 3'b000};
        vecs[3] = '{1'b0, 3'b001, 1'b0, 1'b1, 2'b10, 3'b000};
        vecs[4] = '{1'b0, 3'b010, 1'b1, 1'b1, 2'b00, 3'b000};
        vecs[5] = '{1'b0, 3'b011, 1'b0, 1'b0, 2'b10, 3'b010};
        vecs[6] = '{1'b0, 3'b100, 1'b1, 1'b1, 2'b00, 3'b000};
        vecs[7] = '{1'b0, 3'b101, 1'b0, 1'b0, 2'b10, 3'b100};
        vecs[8] = '{1'b0, 3'b110, 1'b0, 1'b0, 2'b01, 3'b001};
        vecs[9] = '{1'b0, 3'b111, 1'b0, 1'b0, 2'b11, 3'b111};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].abc);
            if (i == 0) consistOn = 1'b1;
            checkOutput($sformatf("vec%0d_abc%b", i, vecs[i].abc),
                        vecs[i].y0, vecs[i].y1, vecs[i].pd0, vecs[i].pd1);
        end

        // Single-input walk 000 -> 100 -> 110.
        applyStimulus(1'b0, 3'b000);
        checkOutput("walk_000", 1'b1, 1'b1, 2'b00, 3'b000);
        applyStimulus(1'b0, 3'b100);
        checkOutput("walk_100", 1'b1, 1'b1, 2'b00, 3'b000);
        applyStimulus(1'b0, 3'b110);
        checkOutput("walk_110", 1'b0, 1'b0, 2'b01, 3'b001);

        // Mid-stream reset with abc held at 011.
        applyStimulus(1'b0, 3'b011);
        checkOutput("mid_pre", 1'b0, 1'b0, 2'b10, 3'b010);
        applyStimulus(1'b1, 3'b011);
        checkOutput("mid_rst", 1'b1, 1'b1, 2'b00, 3'b000);
        applyStimulus(1'b0, 3'b011);
        checkOutput("mid_post", 1'b0, 1'b0, 2'b10, 3'b010);

        // Pulse c between two edges; only the edge value may matter.
        applyStimulus(1'b0, 3'b000);
        checkOutput("glitch_pre", 1'b1, 1'b1, 2'b00, 3'b000);
        bus.c = 1'b1;
        #2;
        bus.c = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("glitch_post", 1'b1, 1'b1, 2'b00, 3'b000);

        // Outputs hold while inputs stay stable.
        applyStimulus(1'b0, 3'b101);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d", i), 1'b0, 1'b0, 2'b10, 3'b100);
        end

        for (int i = 0; i < 300; i++) begin
            rr   = ($urandom_range(0, 15) == 0);
            rabc = 3'($urandom_range(0, 7));
            applyStimulus(rr, rabc);
            refModel(rr, rabc, ey0, ey1, epd0, epd1);
            checkOutput($sformatf("rand%0d_r%b_abc%b", i, rr, rabc), ey0, ey1, epd0, epd1);
        end

        @(negedge clk);
        consistOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
